mem_region_arbiter: RTL
=======================

// Module: mem_region_arbiter
// PURPOSE
//  Parametrised address-space decoder and access sequencer between CPU datapath and memory/I/O.
//  Splits address space into PROGRAM, DATA and IO regions; generates memory enable/write strobes.
//  Drives a ready handshake with region-dependent latency and write protection of program space.
//  Provides a sticky event register bank for player-input flags. Sits between datapath and exmem/controllers.
// PARAMETERS
//  ADDR_W    16       address width
//  DATA_W    16       data width
//  DATA_BASE 16'hA000 first DATA address; below it is PROGRAM
//  IO_BASE   16'hC000 first IO address; DATA_BASE < IO_BASE required
//  N_IO      4        IO input/output slots (power of 2, >=2)
//  IO_WAIT   2        extra wait cycles on IO accesses (0..15)
// PORTS
//  clk        in  1             system clock, rising edge
//  rst        in  1             synchronous active-high reset
//  req        in  1             access request; sampled only in IDLE
//  we         in  1             1=write, 0=read (sampled with req)
//  adr        in  ADDR_W        access address (sampled with req)
//  wdata      in  DATA_W        write data (sampled with req)
//  rdata      out DATA_W        read data, valid while ready=1
//  ready      out 1             one-cycle pulse: access complete
//  prot_fault out 1             one-cycle pulse: write to PROGRAM region rejected
//  mem_en     out 1             memory enable (PROGRAM/DATA access in progress)
//  mem_we     out 1             memory write strobe, 1 cycle
//  mem_rdata  in  DATA_W        memory read data, valid cycle after mem_en
//  io_in      in  N_IO*DATA_W   IO read slots, slot k at [k*DATA_W +: DATA_W]
//  io_out     out N_IO*DATA_W   IO write registers
//  io_wstb    out N_IO          one-cycle strobe per written IO slot
//  evt_in     in  N_IO          event pulses (e.g. player-input flags)
// BEHAVIOUR
//  Reset: all outputs 0, io_out regs 0, event sticky bits 0, FSM -> IDLE. Reset mid-access aborts it; no ready.
//  Decode: adr<DATA_BASE PROGRAM; DATA_BASE<=adr<IO_BASE DATA; adr>=IO_BASE IO; off=adr-IO_BASE.
//  FSM IDLE->MEM on req to PROGRAM/DATA (except PROGRAM write); IDLE->IOW on req to IO; req ignored outside IDLE.
//  PROGRAM write: no state change, mem_we stays 0, prot_fault and ready pulse cycle after req.
//  MEM: mem_en=1 one cycle (mem_we=we); next cycle ready=1, rdata=mem_rdata (read) or 0 (write) -> IDLE.
//  Total MEM latency: req at cycle T -> ready at T+2.
//  IOW: counter loads IO_WAIT, decrements to 0, then DONE cycle: ready=1 -> IDLE. Latency req T -> ready T+2+IO_WAIT.
//  IO read off<N_IO: rdata=io_in slot off sampled in DONE; off==N_IO: rdata={0,sticky[N_IO-1:0]}; else rdata=0.
//  Reading off==N_IO clears sticky bits in DONE cycle; an evt_in pulse same cycle keeps its bit set (set wins).
//  IO write off<N_IO: io_out slot updated and io_wstb[off] pulsed in DONE cycle; other offsets discarded, ready still given.
//  evt_in[k]=1 any cycle sets sticky[k]; only clear-on-read or rst clears it.
//  rdata held 0 except in ready cycle. ready and prot_fault never both set except PROGRAM-write case.
//  Widths: address compares unsigned; off computed ADDR_W wide, no wrap (adr=16'hFFFF is out-of-range IO).
// TESTING
//  DATA read adr=16'hA010, mem_rdata=16'h1234 -> mem_en 1 cycle, ready at T+2, rdata=16'h1234.
//  PROGRAM write adr=16'h0005 -> mem_we never 1, prot_fault+ready at T+1, state IDLE.
//  IO write adr=16'hC002 wdata=16'hBEEF, IO_WAIT=2 -> io_wstb=4'b0100, io_out slot2=16'hBEEF, ready at T+4.
//  evt_in[1] pulse, then read 16'hC004 -> rdata=16'h0002; re-read -> 16'h0000.
//  evt_in[3] pulse in clear cycle of 16'hC004 read -> next read returns 16'h0008.
//  rst asserted during IOW wait -> no ready, outputs 0; new req afterwards completes normally.

Source files
------------

// File: rtl/mem_region_arbiter.sv
// mem_region_arbiter
//   Address-space decoder and access sequencer that sits between the CPU datapath
//   and the memory / IO side. The address space is split into three regions:
//   PROGRAM (below DATA_BASE), DATA (DATA_BASE up to IO_BASE) and IO (IO_BASE
//   and above). Program space is write protected. The block also keeps a bank
//   of sticky event flags that are cleared when they are read.
//
// Ports
//   clk, rst           system clock and synchronous active-high reset
//   req/we/adr/wdata   access request from the datapath, sampled only in IDLE
//   rdata, ready       read data and one-cycle completion pulse
//   prot_fault         one-cycle pulse when a PROGRAM write is rejected
//   mem_en, mem_we     memory enable and write strobe for PROGRAM/DATA
//   mem_rdata          memory read data, valid the cycle after mem_en
//   io_in, io_out      IO read slots and IO write registers (N_IO x DATA_W)
//   io_wstb            per-slot one-cycle write strobe
//   evt_in             event pulses that set the sticky flags
//
// States
//   state      | meaning
//   S_IDLE     | waiting for req; PROGRAM writes are rejected here
//   S_MEM      | mem_en asserted for one cycle
//   S_MEM_RSP  | memory response: ready, rdata from mem_rdata
//   S_IOW      | IO wait counter running down to zero
//   S_IO_DONE  | IO completion: ready, IO read/write and sticky clear

module mem_region_arbiter #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] DATA_BASE = 16'hA000,
    parameter logic [ADDR_W-1:0] IO_BASE   = 16'hC000,
    parameter int                N_IO      = 4,
    parameter int                IO_WAIT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        adr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ready,
    output logic                     prot_fault,
    output logic                     mem_en,
    output logic                     mem_we,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic [N_IO*DATA_W-1:0]   io_in,
    output logic [N_IO*DATA_W-1:0]   io_out,
    output logic [N_IO-1:0]          io_wstb,
    input  logic [N_IO-1:0]          evt_in
);

    localparam int IDX_W = $clog2(N_IO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_MEM_RSP,
        S_IOW,
        S_IO_DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [3:0]               wait_cnt;
    logic                     acc_we;
    logic [ADDR_W-1:0]        acc_off;
    logic [DATA_W-1:0]        acc_wdata;
    logic                     pf_q;
    logic [N_IO-1:0]          sticky;
    logic [N_IO*DATA_W-1:0]   io_out_q;

    logic                     is_prog;
    logic                     is_io;
    logic [ADDR_W-1:0]        req_off;
    logic                     accept;
    logic [IDX_W-1:0]         idx;
    logic                     off_slot;
    logic                     off_evt;
    logic [DATA_W-1:0]        io_slot_rd;
    logic                     io_wr;
    logic                     sticky_clr;

    assign is_prog = adr < DATA_BASE;
    assign is_io   = adr >= IO_BASE;
    // Only meaningful for IO addresses; computed full width so that the top
    // of the address space maps to an out-of-range offset instead of wrapping.
    assign req_off = adr - IO_BASE;
    assign accept  = (state == S_IDLE) && req;

    assign idx        = acc_off[IDX_W-1:0];
    assign off_slot   = acc_off < ADDR_W'(N_IO);
    assign off_evt    = acc_off == ADDR_W'(N_IO);
    assign io_slot_rd = io_in[idx*DATA_W +: DATA_W];
    assign io_wr      = (state == S_IO_DONE) && acc_we && off_slot;
    assign sticky_clr = (state == S_IO_DONE) && !acc_we && off_evt;
    assign io_out     = io_out_q;

    always_comb begin
        state_nxt  = state;
        rdata      = '0;
        ready      = pf_q;
        prot_fault = pf_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        io_wstb    = '0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (is_io) begin
                        state_nxt = S_IOW;
                    end else if (!(is_prog && we)) begin
                        state_nxt = S_MEM;
                    end
                end
            end
            S_MEM: begin
                mem_en    = 1'b1;
                mem_we    = acc_we;
                state_nxt = S_MEM_RSP;
            end
            S_MEM_RSP: begin
                ready     = 1'b1;
                if (!acc_we) begin
                    rdata = mem_rdata;
                end
                state_nxt = S_IDLE;
            end
            S_IOW: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_IO_DONE;
                end
            end
            S_IO_DONE: begin
                ready = 1'b1;
                if (!acc_we) begin
                    if (off_slot) begin
                        rdata = io_slot_rd;
                    end else if (off_evt) begin
                        rdata = DATA_W'(sticky);
                    end
                end
                if (io_wr) begin
                    io_wstb[idx] = 1'b1;
                end
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            acc_we    <= 1'b0;
            acc_off   <= '0;
            acc_wdata <= '0;
            pf_q      <= 1'b0;
            sticky    <= '0;
            io_out_q  <= '0;
        end else begin
            state <= state_nxt;
            pf_q  <= accept && is_prog && we;
            if (accept) begin
                acc_we    <= we;
                acc_off   <= req_off;
                acc_wdata <= wdata;
                wait_cnt  <= 4'(IO_WAIT);
            end else if ((state == S_IOW) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // A new event in the clearing cycle survives the clear.
            if (sticky_clr) begin
                sticky <= evt_in;
            end else begin
                sticky <= sticky | evt_in;
            end
            if (io_wr) begin
                io_out_q[idx*DATA_W +: DATA_W] <= acc_wdata;
            end
        end
    end

endmodule
